pc_sequencer: RTL and testbench

Program-counter sequencer for the 19-bit CPU. It generates the fetch address stream and redirects fetch on taken branches, calls and returns resolved in execute; the taken decision comes from the branch comparator. It owns a return-address stack (RAS) for call/ret and drains wrong-path fetches with a fixed-length flush window.

---
 rtl/pc_sequencer.sv | 110 +++++++++++
 tb/tb_pc_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, execute-resolved redirects
// (branch/call/ret) with a circular return-address stack and a fixed flush window.
module pc_sequencer #(
    parameter int              PC_W         = 19,
    parameter int              RAS_DEPTH    = 8,
    parameter int              FLUSH_CYCLES = 2,
    parameter logic [PC_W-1:0] RESET_PC     = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            fetch_valid_o,
    output logic [PC_W-1:0] fetch_pc_o,
    input  logic            fetch_ready_i,
    input  logic            ex_valid_i,
    input  logic [PC_W-1:0] ex_pc_i,
    input  logic            ex_is_branch_i,
    input  logic            ex_branch_taken_i,
    input  logic            ex_is_call_i,
    input  logic            ex_is_ret_i,
    input  logic [PC_W-1:0] ex_target_i,
    output logic            flush_o,
    output logic            ras_overflow_o,
    output logic            ras_underflow_o,
    output logic [1:0]      state_o
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int BUB_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2, ERR = 2'd3} state_e;

    state_e                            state_q;
    logic [PC_W-1:0]                   pc_q;
    logic [RAS_DEPTH-1:0][PC_W-1:0]    ras_q;
    logic [PTR_W-1:0]                  ptr_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic [BUB_W-1:0]                  bub_q;
    logic                              flush_q, ovf_q, unf_q;

    logic            redirect_d, ras_full_d, ras_empty_d;
    logic [PTR_W-1:0] top_idx_d;
    logic [PC_W-1:0]  ret_addr_d;

    assign redirect_d  = ex_valid_i & (ex_is_ret_i | ex_is_call_i |
                                       (ex_is_branch_i & ex_branch_taken_i));
    assign ras_full_d  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_empty_d = (cnt_q == '0);
    // ptr_q names the next free slot, so the top lives one below it
    assign top_idx_d   = ptr_q - 1'b1;
    assign ret_addr_d  = ex_pc_i + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ras_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            bub_q   <= '0;
            flush_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (redirect_d) begin
                        if (ex_is_ret_i && ras_empty_d) begin
                            state_q <= ERR;
                            unf_q   <= 1'b1;
                        end else begin
                            state_q <= FLUSH;
                            flush_q <= 1'b1;
                            bub_q   <= BUB_W'(FLUSH_CYCLES - 1);
                            if (ex_is_ret_i) begin
                                pc_q  <= ras_q[top_idx_d];
                                ptr_q <= top_idx_d;
                                cnt_q <= cnt_q - 1'b1;
                            end else begin
                                pc_q <= ex_target_i;
                                if (ex_is_call_i) begin
                                    // full stack: the slot at ptr_q is the oldest entry
                                    ras_q[ptr_q] <= ret_addr_d;
                                    ptr_q        <= ptr_q + 1'b1;
                                    if (ras_full_d) ovf_q <= 1'b1;
                                    else            cnt_q <= cnt_q + 1'b1;
                                end
                            end
                        end
                    end else if (fetch_ready_i) begin
                        pc_q <= pc_q + 1'b1;
                    end
                end
                FLUSH: begin
                    if (bub_q == '0) state_q <= RUN;
                    else             bub_q   <= bub_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign fetch_valid_o   = (state_q == RUN);
    assign fetch_pc_o      = pc_q;
    assign flush_o         = flush_q;
    assign ras_overflow_o  = ovf_q;
    assign ras_underflow_o = unf_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, redirects, RAS LIFO/wrap/overflow,
// underflow to ERR, and reset out of FLUSH and ERR.
module tb_pc_sequencer;
    localparam logic [18:0] RPC = 19'h00100;

    logic        clk = 1'b0;
    logic        reset, fetch_valid, fetch_ready, ex_valid, ex_is_branch, ex_taken;
    logic        ex_is_call, ex_is_ret, flush, ovf, unf;
    logic [18:0] fetch_pc, ex_pc, ex_target;
    logic [1:0]  state;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_W(19), .RAS_DEPTH(8), .FLUSH_CYCLES(2), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid_o(fetch_valid), .fetch_pc_o(fetch_pc), .fetch_ready_i(fetch_ready),
        .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .ex_is_branch_i(ex_is_branch),
        .ex_branch_taken_i(ex_taken), .ex_is_call_i(ex_is_call), .ex_is_ret_i(ex_is_ret),
        .ex_target_i(ex_target), .flush_o(flush), .ras_overflow_o(ovf),
        .ras_underflow_o(unf), .state_o(state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic br, input logic tk, input logic cl, input logic rt,
                          input logic [18:0] pc, input logic [18:0] tgt);
        ex_valid = 1'b1; ex_is_branch = br; ex_taken = tk;
        ex_is_call = cl; ex_is_ret = rt; ex_pc = pc; ex_target = tgt;
    endtask

    task automatic ex_clr();
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0;
        ex_is_call = 1'b0; ex_is_ret = 1'b0; ex_pc = '0; ex_target = '0;
    endtask

    // Called with a redirect already driven in a RUN cycle; walks the flush window.
    task automatic redir(input string tag, input logic [18:0] tgt);
        step(); ex_clr();
        chk({tag, " flush1"}, {state, flush, fetch_valid, 13'd0, fetch_pc}, {2'd2, 1'b1, 1'b0, 13'd0, tgt});
        step();
        chk({tag, " flush2"}, {state, flush, fetch_valid}, {2'd2, 1'b0, 1'b0});
        step();
        chk({tag, " resume"}, {state, fetch_valid, 13'd0, fetch_pc}, {2'd1, 1'b1, 13'd0, tgt});
    endtask

    task automatic do_reset();
        reset = 1'b1; step();
        chk("reset state", {state, flush, fetch_valid, ovf, unf}, {2'd0, 4'b0000});
        chk("reset pc", fetch_pc, RPC);
        reset = 1'b0; step();
        chk("boot->run", {state, fetch_valid, 13'd0, fetch_pc}, {2'd1, 1'b1, 13'd0, RPC});
    endtask

    initial begin
        reset = 1'b1; fetch_ready = 1'b1; ex_clr();
        step();
        do_reset();
        step(); chk("seq 101", fetch_pc, 19'h00101);
        step(); chk("seq 102", fetch_pc, 19'h00102);
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall hold", {fetch_valid, 13'd0, fetch_pc}, {1'b1, 13'd0, 19'h00102});
        end
        fetch_ready = 1'b1;

        ex_set(1, 1, 0, 0, 19'h00050, 19'h00040); redir("taken br", 19'h00040);
        ex_set(1, 0, 0, 0, 19'h00050, 19'h00777); step(); ex_clr();
        chk("not taken", {state, flush, 13'd0, fetch_pc}, {2'd1, 1'b0, 13'd0, 19'h00041});
        ex_valid = 1'b0; ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 19'h00777;
        step(); ex_clr();
        chk("br no valid", {state, flush, 13'd0, fetch_pc}, {2'd1, 1'b0, 13'd0, 19'h00042});

        ex_set(0, 0, 1, 0, 19'h7FFFF, 19'h00200); redir("call wrap", 19'h00200);
        ex_set(0, 0, 0, 1, 19'h00201, 19'h00000); redir("ret wrap", 19'h00000);

        ex_set(0, 0, 1, 0, 19'h00010, 19'h00300); redir("ncall1", 19'h00300);
        ex_set(0, 0, 1, 0, 19'h00020, 19'h00400); redir("ncall2", 19'h00400);
        ex_set(0, 0, 1, 0, 19'h00030, 19'h00500); redir("ncall3", 19'h00500);
        ex_set(0, 0, 0, 1, 19'h00501, 19'h0); redir("nret1", 19'h00031);
        ex_set(0, 0, 0, 1, 19'h00032, 19'h0); redir("nret2", 19'h00021);
        ex_set(0, 0, 0, 1, 19'h00022, 19'h0); redir("nret3", 19'h00011);

        ex_set(0, 0, 1, 0, 19'h00054, 19'h00600); redir("call 55", 19'h00600);
        // call+ret together: ret wins; a taken branch arriving in FLUSH is dropped
        ex_set(0, 0, 1, 1, 19'h00099, 19'h00777); step();
        chk("call+ret", {state, flush, 13'd0, fetch_pc}, {2'd2, 1'b1, 13'd0, 19'h00055});
        ex_set(1, 1, 0, 0, 19'h00123, 19'h00123); step(); ex_clr();
        chk("flush ignore", {state, 13'd0, fetch_pc}, {2'd2, 13'd0, 19'h00055});
        step();
        chk("call+ret resume", {state, fetch_valid, 13'd0, fetch_pc}, {2'd1, 1'b1, 13'd0, 19'h00055});
        // stack must be empty now, so this ret underflows
        ex_set(0, 0, 0, 1, 19'h00055, 19'h0); step(); ex_clr();
        chk("underflow", {state, unf, flush, fetch_valid, 13'd0, fetch_pc},
            {2'd3, 1'b1, 1'b0, 1'b0, 13'd0, 19'h00055});
        ex_set(1, 1, 0, 0, 19'h0, 19'h00200); step(); ex_clr(); step();
        chk("err stays", {state, fetch_valid, flush, 13'd0, fetch_pc}, {2'd3, 1'b0, 1'b0, 13'd0, 19'h00055});

        do_reset();
        step(); chk("post err seq", fetch_pc, 19'h00101);

        for (int i = 1; i <= 9; i++) begin
            ex_set(0, 0, 1, 0, 19'(i * 16), 19'(19'h01000 + i));
            redir("ovf call", 19'(19'h01000 + i));
            chk("ovf flag", ovf, (i == 9) ? 1'b1 : 1'b0);
        end
        for (int i = 9; i >= 2; i--) begin
            ex_set(0, 0, 0, 1, 19'h0, 19'h0);
            redir("ovf ret", 19'(i * 16 + 1));
        end
        ex_set(0, 0, 0, 1, 19'h0, 19'h0); step(); ex_clr();
        chk("ninth ret", {state, unf, ovf, fetch_valid, 13'd0, fetch_pc},
            {2'd3, 1'b1, 1'b1, 1'b0, 13'd0, 19'h00021});
        step(); chk("ninth ret valid", fetch_valid, 1'b0);

        do_reset();
        ex_set(1, 1, 0, 0, 19'h0, 19'h00040); step(); ex_clr(); step();
        chk("2nd flush", state, 2'd2);
        reset = 1'b1; step();
        chk("reset in flush", {state, flush, fetch_valid, ovf, unf, 13'd0, fetch_pc},
            {2'd0, 4'b0000, 13'd0, RPC});
        reset = 1'b0; step();
        chk("flush rst run", {state, fetch_valid, 13'd0, fetch_pc}, {2'd1, 1'b1, 13'd0, RPC});
        step(); chk("flush rst seq", fetch_pc, 19'h00101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
